// File: rtl/ycbcr_encoder.sv
// RGB565/RGB888 to YCbCr encoder: BT.601/BT.709, limited/full range, 4:4:4 or 4:2:2 output.
// Fixed 4-cycle pipeline; mode changes take effect only at the vsync falling edge.
module ycbcr_encoder #(
   parameter int unsigned IN_FMT     = 0,
   parameter int unsigned CHROMA_AVG = 1
) (
   input  logic        pixel_clk,
   input  logic        rst_n,
   input  logic [23:0] rgb_in,
   input  logic        de_in,
   input  logic        hsync_in,
   input  logic        vsync_in,
   input  logic        cfg_bt709,
   input  logic        cfg_full,
   input  logic        cfg_444,
   output logic [23:0] ycbcr_out,
   output logic        de_out,
   output logic        hsync_out,
   output logic        vsync_out,
   output logic        cfg_applied
);

   // Rows Y, Cb, Cr as (R,G,B), indexed by {bt709, full}.
   localparam logic signed [8:0] COEF [4][9] = '{
      '{9'sd66, 9'sd129, 9'sd25, -9'sd38, -9'sd74,  9'sd112, 9'sd112, -9'sd94,  -9'sd18},
      '{9'sd77, 9'sd150, 9'sd29, -9'sd43, -9'sd85,  9'sd128, 9'sd128, -9'sd107, -9'sd21},
      '{9'sd47, 9'sd157, 9'sd16, -9'sd26, -9'sd86,  9'sd112, 9'sd112, -9'sd102, -9'sd10},
      '{9'sd54, 9'sd183, 9'sd19, -9'sd29, -9'sd99,  9'sd128, 9'sd128, -9'sd116, -9'sd12}
   };

   function automatic logic signed [17:0] dot(input logic signed [8:0] kr, input logic signed [8:0] kg,
                                              input logic signed [8:0] kb, input logic [7:0] r,
                                              input logic [7:0] g, input logic [7:0] b);
      logic signed [17:0] pr, pg, pb;
      pr = 18'(kr) * 18'($signed({1'b0, r}));
      pg = 18'(kg) * 18'($signed({1'b0, g}));
      pb = 18'(kb) * 18'($signed({1'b0, b}));
      return pr + pg + pb + 18'sd128;
   endfunction

   function automatic logic [7:0] clamp(input logic signed [17:0] sum, input logic [7:0] off,
                                        input logic [7:0] lo, input logic [7:0] hi);
      logic signed [10:0] v;
      v = $signed({sum[17], sum[17:8]}) + $signed({3'b000, off});
      if (v < $signed({3'b000, lo})) return lo;
      else if (v > $signed({3'b000, hi})) return hi;
      else return v[7:0];
   endfunction

   // Active (shadowed) configuration
   logic bt709_q, full_q, c444_q, vs_prev_q, vs_fall;

   assign vs_fall = vs_prev_q & ~vsync_in;

   always_ff @(posedge pixel_clk or negedge rst_n) begin
      if (!rst_n) begin
         vs_prev_q   <= 1'b1;
         bt709_q     <= 1'b0;
         full_q      <= 1'b0;
         c444_q      <= 1'b0;
         cfg_applied <= 1'b0;
      end else begin
         vs_prev_q   <= vsync_in;
         cfg_applied <= vs_fall;
         if (vs_fall) begin
            bt709_q <= cfg_bt709;
            full_q  <= cfg_full;
            c444_q  <= cfg_444;
         end
      end
   end

   // Stage 1: expansion and pixel phase
   logic [7:0] r8, g8, b8;
   logic [7:0] r1_q, g1_q, b1_q;
   logic       phase_q, de1_q, ph1_q, hs1_q, vs1_q;

   always_comb begin
      if (IN_FMT == 0) begin
         r8 = {rgb_in[15:11], rgb_in[15:13]};
         g8 = {rgb_in[10:5], rgb_in[10:9]};
         b8 = {rgb_in[4:0], rgb_in[4:2]};
      end else begin
         r8 = rgb_in[23:16];
         g8 = rgb_in[15:8];
         b8 = rgb_in[7:0];
      end
   end

   always_ff @(posedge pixel_clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q <= 1'b0;
         r1_q    <= 8'd0;
         g1_q    <= 8'd0;
         b1_q    <= 8'd0;
         de1_q   <= 1'b0;
         ph1_q   <= 1'b0;
         hs1_q   <= 1'b1;
         vs1_q   <= 1'b1;
      end else begin
         phase_q <= de_in ? ~phase_q : 1'b0;
         r1_q    <= r8;
         g1_q    <= g8;
         b1_q    <= b8;
         de1_q   <= de_in;
         ph1_q   <= phase_q;
         hs1_q   <= hsync_in;
         vs1_q   <= vsync_in;
      end
   end

   // Stage 2: matrix, rounding, offset and saturation
   logic [1:0]         mode;
   logic signed [17:0] sum_y, sum_cb, sum_cr;
   logic [7:0]         off_y, lo_v, hi_y, hi_c;
   logic [7:0]         y2_q, cb2_q, cr2_q;
   logic               de2_q, ph2_q, hs2_q, vs2_q;

   always_comb begin
      mode   = {bt709_q, full_q};
      sum_y  = dot(COEF[mode][0], COEF[mode][1], COEF[mode][2], r1_q, g1_q, b1_q);
      sum_cb = dot(COEF[mode][3], COEF[mode][4], COEF[mode][5], r1_q, g1_q, b1_q);
      sum_cr = dot(COEF[mode][6], COEF[mode][7], COEF[mode][8], r1_q, g1_q, b1_q);
      off_y  = full_q ? 8'd0 : 8'd16;
      lo_v   = full_q ? 8'd0 : 8'd16;
      hi_y   = full_q ? 8'd255 : 8'd235;
      hi_c   = full_q ? 8'd255 : 8'd240;
   end

   always_ff @(posedge pixel_clk or negedge rst_n) begin
      if (!rst_n) begin
         y2_q  <= 8'd0;
         cb2_q <= 8'd0;
         cr2_q <= 8'd0;
         de2_q <= 1'b0;
         ph2_q <= 1'b0;
         hs2_q <= 1'b1;
         vs2_q <= 1'b1;
      end else begin
         y2_q  <= clamp(sum_y, off_y, lo_v, hi_y);
         cb2_q <= clamp(sum_cb, 8'd128, lo_v, hi_c);
         cr2_q <= clamp(sum_cr, 8'd128, lo_v, hi_c);
         de2_q <= de1_q;
         ph2_q <= ph1_q;
         hs2_q <= hs1_q;
         vs2_q <= vs1_q;
      end
   end

   // Stage 3: holds the even pixel while its odd partner sits in stage 2
   logic [7:0] y3_q, cb3_q, cr3_q;
   logic       de3_q, ph3_q, hs3_q, vs3_q;

   always_ff @(posedge pixel_clk or negedge rst_n) begin
      if (!rst_n) begin
         y3_q  <= 8'd0;
         cb3_q <= 8'd0;
         cr3_q <= 8'd0;
         de3_q <= 1'b0;
         ph3_q <= 1'b0;
         hs3_q <= 1'b1;
         vs3_q <= 1'b1;
      end else begin
         y3_q  <= y2_q;
         cb3_q <= cb2_q;
         cr3_q <= cr2_q;
         de3_q <= de2_q;
         ph3_q <= ph2_q;
         hs3_q <= hs2_q;
         vs3_q <= vs2_q;
      end
   end

   // Stage 4: 4:2:2 chroma selection, blanking and output registers
   logic       pair;
   logic [8:0] avg_cb, avg_cr;
   logic [7:0] chroma, cr_pair_q, cr_pair_d;
   logic [23:0] data_d;

   always_comb begin
      pair      = de3_q & ~ph3_q & de2_q;
      avg_cb    = {1'b0, cb3_q} + {1'b0, cb2_q} + 9'd1;
      avg_cr    = {1'b0, cr3_q} + {1'b0, cr2_q} + 9'd1;
      cr_pair_d = pair ? avg_cr[8:1] : cr_pair_q;
      chroma    = cb3_q;
      if (!ph3_q) begin
         if (pair && CHROMA_AVG != 0) chroma = avg_cb[8:1];
      end else begin
         chroma = (CHROMA_AVG != 0) ? cr_pair_q : cr3_q;
      end
      if (!de3_q)      data_d = {c444_q ? 8'h80 : 8'h00, 8'h80, full_q ? 8'h00 : 8'h10};
      else if (c444_q) data_d = {cr3_q, cb3_q, y3_q};
      else             data_d = {8'h00, chroma, y3_q};
   end

   always_ff @(posedge pixel_clk or negedge rst_n) begin
      if (!rst_n) begin
         cr_pair_q <= 8'd0;
         ycbcr_out <= 24'h008010;
         de_out    <= 1'b0;
         hsync_out <= 1'b1;
         vsync_out <= 1'b1;
      end else begin
         cr_pair_q <= cr_pair_d;
         ycbcr_out <= data_d;
         de_out    <= de3_q;
         hsync_out <= hs3_q;
         vsync_out <= vs3_q;
      end
   end

endmodule

// File: doc/ycbcr_encoder.md
# ycbcr_encoder

Parametrised RGB-to-YCbCr encoder for the video output path, sitting between the scan-out pixel stream and the ADV7511 pixel bus. It extends the fixed BT.601/4:2:2 converter with several additions: RGB565 or RGB888 input, a BT.601/BT.709 matrix select, limited or full range, 4:4:4 or 4:2:2 output, and optional chroma-pair averaging. Runtime mode changes are shadowed to the frame boundary so a frame never mixes modes.

## Interface
- IN_FMT, 0: input format; 0 = RGB565 in `rgb_in[15:0]`, 1 = RGB888 in `rgb_in[23:0]` as {R,G,B}.
- CHROMA_AVG, 1: 4:2:2 chroma source; 1 = average of the pixel pair, 0 = even pixel's Cb and odd pixel's Cr (co-sited drop).

Ports:
- pixel_clk  in  1  pixel clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- rgb_in  in  24  pixel data; bits [23:16] are ignored when IN_FMT=0.
- de_in  in  1  data enable.
- hsync_in  in  1  horizontal sync, active-low.
- vsync_in  in  1  vertical sync, active-low.
- cfg_bt709  in  1  matrix select; 0 = BT.601, 1 = BT.709.
- cfg_full  in  1  range select; 0 = limited, 1 = full.
- cfg_444  in  1  output format; 0 = 4:2:2, 1 = 4:4:4.
- ycbcr_out  out  24  4:4:4 = {Cr,Cb,Y}; 4:2:2 = {8'h00,C,Y}.
- de_out  out  1  delayed `de_in`.
- hsync_out  out  1  delayed `hsync_in`.
- vsync_out  out  1  delayed `vsync_in`.
- cfg_applied  out  1  one-cycle pulse when the shadow configuration loads.

## Operation
- **Expansion.**
  - RGB565: R8={r5,r5[4:2]}, G8={g6,g6[5:4]}, B8={b5,b5[4:2]}.
  - RGB888: components are passed through.
- **Coefficients.** All are ×256 and listed as Y / Cb / Cr rows, each row as (R,G,B):
  - BT.601 limited: Y 66,129,25; Cb −38,−74,112; Cr 112,−94,−18.
  - BT.601 full: Y 77,150,29; Cb −43,−85,128; Cr 128,−107,−21.
  - BT.709 limited: Y 47,157,16; Cb −26,−86,112; Cr 112,−102,−10.
  - BT.709 full: Y 54,183,19; Cb −29,−99,128; Cr 128,−116,−12.
- **Arithmetic.**
  - Sums use 18-bit signed arithmetic. Each component is (sum+128)>>>8 (arithmetic shift), plus an offset.
  - Offsets: Y +16 when limited, +0 when full; Cb/Cr +128.
  - Saturation: limited range clamps Y to [16,235] and C to [16,240]; full range clamps to [0,255].
- **Pixel phase.** Resets to even whenever `de_in`=0 and toggles on every DE pixel. The first pixel of each line is even.
- **4:2:2 pairing.**
  - Even pixel outputs {Cb,Y}; odd pixel outputs {Cr,Y}.
  - With CHROMA_AVG=1, the pair uses Cb=(Cb_e+Cb_o+1)>>1 and Cr=(Cr_e+Cr_o+1)>>1.
  - An even pixel with no odd partner (DE falls after it) uses its own Cb.
- **4:4:4 output.** Outputs {Cr,Cb,Y} per pixel; pairing logic is bypassed.
- **Blanking.** When `de_out`=0, `ycbcr_out` is black for the active mode:
  - 4:2:2 limited 0x008010, 4:2:2 full 0x008000.
  - 4:4:4 limited 0x808010, 4:4:4 full 0x808000.
- **Config shadowing.**
  - `cfg_*` are sampled into the active registers on the cycle after `vsync_in` falls (1→0); `cfg_applied` pulses that same cycle.
  - A falling edge with an unchanged configuration still pulses `cfg_applied`.
  - The active configuration is otherwise frozen. Pixels already in the pipeline are blanking and emit blank for the new mode.

## Timing
- Fixed latency of 4 pixel_clk cycles, `rgb_in` to `ycbcr_out`, in all modes.
- `de`, `hsync` and `vsync` are delayed by exactly 4 cycles with the data.
- The 4:2:2 lookahead for the odd partner is absorbed inside those 4 stages; there is no mode-dependent latency.
- Throughput is one pixel per clock. There is no backpressure.
- Reset values: `ycbcr_out`=0x008010, `de_out`=0, `hsync_out`=1, `vsync_out`=1, `cfg_applied`=0. The active configuration resets to BT.601 / limited / 4:2:2.
- Reset asserted mid-line forces all outputs to their reset values immediately. After release, the first valid output appears 4 cycles after the first DE input.
- A DE gap of one cycle inside a line counts as a line end: phase resets, and a trailing unpaired even pixel uses the lone-pixel rule.

## Test plan
- **Reset.** Assert `rst_n` mid-frame -> outputs go to 0x008010/0/1/1 immediately. First `de_out`=1 appears exactly 4 cycles after the first `de_in`=1 following release.
- **BT.601 limited, 4:2:2, IN_FMT=0, CHROMA_AVG=0.** Pixels 0xF800, 0x001F -> 0x005A52 then 0x006E29 (red Y82 Cb90; blue Y41 Cr110). 0xFFFF -> Y=235. 0x0000 -> Y=16.
- **CHROMA_AVG=1, same pair.** -> 0x00A552 then 0x00AF29 (Cb 165, Cr 175).
- **Full-range 4:4:4.** BT.601 white 0xFFFF -> 0x8080FF. Blanking -> 0x808000. BT.709 full red (RGB888 0xFF0000) -> Y=54, Cb=99, Cr=255.
- **Odd line length 3, 4:2:2 averaged.** The third pixel outputs its own Cb. The next line starts even.
- **Config shadowing.** Change `cfg_*` mid-active-video -> output is unchanged until `vsync_in` falls. `cfg_applied` pulses once, one cycle after the edge. The new blank code appears on the following blanking output.
